// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the MIPS register file and its load-pending
//   scoreboard.
//   INSTR_WIDTH : datapath width, taken from `INSTR_WIDTH (default 32)
//   REG_ADDR_W  : register address width (5, for 32 architectural registers)
//   REG_ZERO    : address of the hardwired zero register
//   PEND_MAX    : saturation value of a scoreboard counter
// -----------------------------------------------------------------------------
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package regfile_pkg;

  localparam int INSTR_WIDTH = `INSTR_WIDTH;
  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 1 << REG_ADDR_W;
  localparam int PEND_MAX    = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Per-register count of loads issued by ID that have not yet written back.
//   ID uses it to stall on load-use hazards.
//   clk, resetn        : clock, asynchronous active-low reset
//   inc_en, inc_addr   : a load to inc_addr is issued this cycle (addr != 0)
//   dec_en, dec_addr   : a load write-back to dec_addr happens this cycle
//   rs_addr, rt_addr   : source registers read by ID
//   stall              : rs or rt still waits on a load that is not the one
//                        completing this cycle
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = NUM_REGS,
  parameter int PEND_W = 2
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      inc_en,
  input  reg_addr_t inc_addr,
  input  logic      dec_en,
  input  reg_addr_t dec_addr,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output logic      stall
);

  localparam logic [PEND_W-1:0] PMAX = PEND_W'(PEND_MAX);

  logic [PEND_W-1:0] pend     [NREG];
  logic [PEND_W-1:0] pend_nxt [NREG];

  // A register is busy if it still has pending loads after the one
  // completing this cycle (which the read bypass already covers).
  function automatic logic busy(input logic [PEND_W-1:0] cnt, input logic done_now);
    if (done_now) return cnt > PEND_W'(1);
    return cnt != '0;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      logic inc_hit;
      logic dec_hit;
      inc_hit     = inc_en && (inc_addr == REG_ADDR_W'(i));
      dec_hit     = dec_en && (dec_addr == REG_ADDR_W'(i));
      pend_nxt[i] = pend[i];
      if (i != 0) begin
        // Issue and completion on the same register cancel out.
        if (inc_hit && !dec_hit && pend[i] != PMAX)
          pend_nxt[i] = pend[i] + PEND_W'(1);
        else if (dec_hit && !inc_hit && pend[i] != '0)
          pend_nxt[i] = pend[i] - PEND_W'(1);
      end else begin
        pend_nxt[i] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) pend[i] <= pend_nxt[i];
    end
  end

  assign stall = busy(pend[rs_addr], dec_en && (dec_addr == rs_addr))
               | busy(pend[rt_addr], dec_en && (dec_addr == rt_addr));

`ifndef SYNTHESIS
  // Overflow and underflow mean the pipeline lost track of a load.
  always @(posedge clk) begin
    if (resetn) begin
      if (inc_en && !(dec_en && dec_addr == inc_addr))
        assert (pend[inc_addr] != PMAX)
          else $error("regfile_scoreboard: load issued to r%0d with counter saturated", inc_addr);
      if (dec_en && !(inc_en && inc_addr == dec_addr))
        assert (pend[dec_addr] != '0)
          else $error("regfile_scoreboard: load write-back to r%0d with no load pending", dec_addr);
    end
  end
`endif

endmodule

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//   MIPS general-purpose register file at the sink end of write-back.
//   clk, resetn                       : clock, asynchronous active-low reset
//   W_WB_addr/_w_reg_ena/_wb_data     : write port from WB
//   W_WB_is_load                      : WB instruction is a load (retires a
//                                       scoreboard entry)
//   D_rs_addr/D_rs_data               : combinational read port A with bypass
//   D_rt_addr/D_rt_data               : combinational read port B with bypass
//   D_issue_load/D_issue_rd           : ID issues a load to D_issue_rd
//   D_stall                           : load-use hazard on rs or rt
//   dbg_wen/dbg_wnum/dbg_wdata        : registered write-back trace
//   dbg_wcount                        : wrapping count of architectural writes
// -----------------------------------------------------------------------------
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = INSTR_WIDTH,
  parameter int NREG   = NUM_REGS,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [4:0]        W_WB_addr,
  input  logic              W_WB_w_reg_ena,
  input  logic [DATA_W-1:0] W_WB_wb_data,
  input  logic              W_WB_is_load,
  input  logic [4:0]        D_rs_addr,
  input  logic [4:0]        D_rt_addr,
  output logic [DATA_W-1:0] D_rs_data,
  output logic [DATA_W-1:0] D_rt_data,
  input  logic              D_issue_load,
  input  logic [4:0]        D_issue_rd,
  output logic              D_stall,
  output logic              dbg_wen,
  output logic [4:0]        dbg_wnum,
  output logic [DATA_W-1:0] dbg_wdata,
  output logic [31:0]       dbg_wcount
);

  logic [DATA_W-1:0] regs [NREG];

  logic wr_en;
  logic issue_en;

  // Writes to r0 are architecturally dropped: no storage, bypass or trace.
  assign wr_en    = W_WB_w_reg_ena && (W_WB_addr != REG_ZERO);
  assign issue_en = D_issue_load && (D_issue_rd != REG_ZERO);

  // NOTE: the array is built from flops rather than a RAM macro, so it can
  // take the asynchronous clear the architecture demands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[W_WB_addr] <= W_WB_wb_data;
    end
  end

  // Write-first bypass. Gating with resetn keeps read data at zero for the
  // whole reset, even if WB happens to hold a write enable.
  always_comb begin
    D_rs_data = '0;
    D_rt_data = '0;
    if (resetn && D_rs_addr != REG_ZERO)
      D_rs_data = (wr_en && D_rs_addr == W_WB_addr) ? W_WB_wb_data : regs[D_rs_addr];
    if (resetn && D_rt_addr != REG_ZERO)
      D_rt_data = (wr_en && D_rt_addr == W_WB_addr) ? W_WB_wb_data : regs[D_rt_addr];
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk      (clk),
    .resetn   (resetn),
    .inc_en   (issue_en),
    .inc_addr (D_issue_rd),
    .dec_en   (wr_en && W_WB_is_load),
    .dec_addr (W_WB_addr),
    .rs_addr  (D_rs_addr),
    .rt_addr  (D_rt_addr),
    .stall    (D_stall)
  );

  // Trace: wen pulses for one cycle per write; number and data hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dbg_wen    <= 1'b0;
      dbg_wnum   <= '0;
      dbg_wdata  <= '0;
      dbg_wcount <= '0;
    end else begin
      dbg_wen <= wr_en;
      if (wr_en) begin
        dbg_wnum   <= W_WB_addr;
        dbg_wdata  <= W_WB_wb_data;
        dbg_wcount <= dbg_wcount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// -----------------------------------------------------------------------------
// tb_regfile
//   Directed self-checking bench for regfile. Inputs change 1 time unit after
//   a rising edge; outputs are sampled 1 time unit after inputs settle, well
//   before the next rising edge.
// -----------------------------------------------------------------------------
module tb_regfile;

  logic        clk;
  logic        resetn;
  logic [4:0]  W_WB_addr;
  logic        W_WB_w_reg_ena;
  logic [31:0] W_WB_wb_data;
  logic        W_WB_is_load;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [31:0] D_rs_data;
  logic [31:0] D_rt_data;
  logic        D_issue_load;
  logic [4:0]  D_issue_rd;
  logic        D_stall;
  logic        dbg_wen;
  logic [4:0]  dbg_wnum;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_wcount;

  int n_pass  = 0;
  int n_total = 0;

  regfile dut (
    .clk            (clk),
    .resetn         (resetn),
    .W_WB_addr      (W_WB_addr),
    .W_WB_w_reg_ena (W_WB_w_reg_ena),
    .W_WB_wb_data   (W_WB_wb_data),
    .W_WB_is_load   (W_WB_is_load),
    .D_rs_addr      (D_rs_addr),
    .D_rt_addr      (D_rt_addr),
    .D_rs_data      (D_rs_data),
    .D_rt_data      (D_rt_data),
    .D_issue_load   (D_issue_load),
    .D_issue_rd     (D_issue_rd),
    .D_stall        (D_stall),
    .dbg_wen        (dbg_wen),
    .dbg_wnum       (dbg_wnum),
    .dbg_wdata      (dbg_wdata),
    .dbg_wcount     (dbg_wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_idle();
    W_WB_w_reg_ena = 1'b0;
    W_WB_is_load   = 1'b0;
    W_WB_addr      = 5'd0;
    W_WB_wb_data   = 32'd0;
  endtask

  task automatic wb_drive(input logic [4:0] a, input logic [31:0] d, input logic ld);
    W_WB_w_reg_ena = 1'b1;
    W_WB_addr      = a;
    W_WB_wb_data   = d;
    W_WB_is_load   = ld;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    D_issue_load = 1'b1;
    D_issue_rd   = rd;
    step();
    D_issue_load = 1'b0;
    D_issue_rd   = 5'd0;
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    wb_idle();
    D_issue_load = 1'b0;
    D_issue_rd   = 5'd0;
    D_rs_addr    = 5'd5;
    D_rt_addr    = 5'd31;
    repeat (3) step();
    resetn = 1'b1;
    step();
    #1;
    n_total++; if (D_rs_data !== 32'd0) $display("FAIL reset_rs: got %h expected 0", D_rs_data); else n_pass++;
    n_total++; if (D_rt_data !== 32'd0) $display("FAIL reset_rt: got %h expected 0", D_rt_data); else n_pass++;
    n_total++; if (dbg_wcount !== 32'd0) $display("FAIL reset_wcount: got %0d expected 0", dbg_wcount); else n_pass++;
    n_total++; if (D_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", D_stall); else n_pass++;
    n_total++; if (dbg_wen !== 1'b0) $display("FAIL reset_wen: got %b expected 0", dbg_wen); else n_pass++;
  endtask

  task automatic test_write_bypass();
    D_rs_addr = 5'd7;
    D_rt_addr = 5'd0;
    wb_drive(5'd7, 32'hDEADBEEF, 1'b0);
    #1;
    n_total++; if (D_rs_data !== 32'hDEADBEEF) $display("FAIL bypass_r7: got %h expected deadbeef", D_rs_data); else n_pass++;
    step();
    wb_idle();
    #1;
    n_total++; if (dbg_wen !== 1'b1) $display("FAIL trace_wen: got %b expected 1", dbg_wen); else n_pass++;
    n_total++; if (dbg_wnum !== 5'd7) $display("FAIL trace_wnum: got %0d expected 7", dbg_wnum); else n_pass++;
    n_total++; if (dbg_wdata !== 32'hDEADBEEF) $display("FAIL trace_wdata: got %h expected deadbeef", dbg_wdata); else n_pass++;
    n_total++; if (dbg_wcount !== 32'd1) $display("FAIL trace_wcount: got %0d expected 1", dbg_wcount); else n_pass++;
    n_total++; if (D_rs_data !== 32'hDEADBEEF) $display("FAIL stored_r7: got %h expected deadbeef", D_rs_data); else n_pass++;
    step();
    #1;
    n_total++; if (dbg_wen !== 1'b0) $display("FAIL trace_wen_drop: got %b expected 0", dbg_wen); else n_pass++;
    n_total++; if (dbg_wnum !== 5'd7) $display("FAIL trace_wnum_hold: got %0d expected 7", dbg_wnum); else n_pass++;
  endtask

  task automatic test_r0_write();
    D_rs_addr = 5'd0;
    D_rt_addr = 5'd0;
    wb_drive(5'd0, 32'h12345678, 1'b0);
    #1;
    n_total++; if (D_rs_data !== 32'd0) $display("FAIL r0_bypass_rs: got %h expected 0", D_rs_data); else n_pass++;
    n_total++; if (D_rt_data !== 32'd0) $display("FAIL r0_bypass_rt: got %h expected 0", D_rt_data); else n_pass++;
    step();
    wb_idle();
    #1;
    n_total++; if (D_rs_data !== 32'd0) $display("FAIL r0_stored: got %h expected 0", D_rs_data); else n_pass++;
    n_total++; if (dbg_wen !== 1'b0) $display("FAIL r0_trace_wen: got %b expected 0", dbg_wen); else n_pass++;
    n_total++; if (dbg_wcount !== 32'd1) $display("FAIL r0_wcount: got %0d expected 1", dbg_wcount); else n_pass++;
  endtask

  task automatic test_load_use();
    D_rs_addr = 5'd0;
    D_rt_addr = 5'd0;
    issue_load(5'd9);
    D_rt_addr = 5'd9;
    #1;
    n_total++; if (D_stall !== 1'b1) $display("FAIL load_use_stall0: got %b expected 1", D_stall); else n_pass++;
    step();
    #1;
    n_total++; if (D_stall !== 1'b1) $display("FAIL load_use_stall1: got %b expected 1", D_stall); else n_pass++;
    wb_drive(5'd9, 32'hA5A50009, 1'b1);
    #1;
    n_total++; if (D_stall !== 1'b0) $display("FAIL load_done_stall: got %b expected 0", D_stall); else n_pass++;
    n_total++; if (D_rt_data !== 32'hA5A50009) $display("FAIL load_done_bypass: got %h expected a5a50009", D_rt_data); else n_pass++;
    step();
    wb_idle();
    #1;
    n_total++; if (D_stall !== 1'b0) $display("FAIL load_after_stall: got %b expected 0", D_stall); else n_pass++;
    n_total++; if (D_rt_data !== 32'hA5A50009) $display("FAIL load_stored_r9: got %h expected a5a50009", D_rt_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    D_rs_addr = 5'd0;
    D_rt_addr = 5'd0;
    D_issue_load = 1'b1;
    D_issue_rd   = 5'd4;
    step();
    step();
    D_issue_load = 1'b0;
    D_issue_rd   = 5'd0;
    D_rs_addr    = 5'd4;
    #1;
    n_total++; if (D_stall !== 1'b1) $display("FAIL b2b_pend2: got %b expected 1", D_stall); else n_pass++;
    wb_drive(5'd4, 32'h00000044, 1'b1);
    #1;
    n_total++; if (D_stall !== 1'b1) $display("FAIL b2b_first_wb: got %b expected 1", D_stall); else n_pass++;
    step();
    wb_idle();
    #1;
    n_total++; if (D_stall !== 1'b1) $display("FAIL b2b_pend1: got %b expected 1", D_stall); else n_pass++;
    wb_drive(5'd4, 32'h00000444, 1'b1);
    #1;
    n_total++; if (D_stall !== 1'b0) $display("FAIL b2b_second_wb: got %b expected 0", D_stall); else n_pass++;
    n_total++; if (D_rs_data !== 32'h00000444) $display("FAIL b2b_bypass: got %h expected 00000444", D_rs_data); else n_pass++;
    step();
    wb_idle();
    #1;
    n_total++; if (D_stall !== 1'b0) $display("FAIL b2b_pend0: got %b expected 0", D_stall); else n_pass++;
  endtask

  task automatic test_same_cycle();
    D_rs_addr = 5'd0;
    D_rt_addr = 5'd0;
    issue_load(5'd3);
    // Issue and complete on r3 together while pend[3] = 1.
    D_rs_addr    = 5'd3;
    D_issue_load = 1'b1;
    D_issue_rd   = 5'd3;
    wb_drive(5'd3, 32'h00000033, 1'b1);
    step();
    D_issue_load = 1'b0;
    D_issue_rd   = 5'd0;
    wb_idle();
    #1;
    n_total++; if (D_stall !== 1'b1) $display("FAIL same_cycle_pend: got %b expected 1", D_stall); else n_pass++;
    // A single completion must clear it, proving the counter held at 1.
    wb_drive(5'd3, 32'h00000034, 1'b1);
    #1;
    n_total++; if (D_stall !== 1'b0) $display("FAIL same_cycle_exact: got %b expected 0", D_stall); else n_pass++;
    step();
    wb_idle();
    #1;
    n_total++; if (D_rs_data !== 32'h00000034) $display("FAIL same_cycle_r3: got %h expected 00000034", D_rs_data); else n_pass++;
    n_total++; if (dbg_wcount !== 32'd6) $display("FAIL wcount_total: got %0d expected 6", dbg_wcount); else n_pass++;
  endtask

  task automatic test_reset_mid();
    D_rs_addr = 5'd0;
    D_rt_addr = 5'd0;
    issue_load(5'd3);
    issue_load(5'd3);
    D_rs_addr = 5'd3;
    #1;
    n_total++; if (D_stall !== 1'b1) $display("FAIL mid_pre_stall: got %b expected 1", D_stall); else n_pass++;
    n_total++; if (D_rs_data !== 32'h00000034) $display("FAIL mid_pre_r3: got %h expected 00000034", D_rs_data); else n_pass++;
    #1;
    resetn = 1'b0;
    #1;
    n_total++; if (D_rs_data !== 32'd0) $display("FAIL mid_reset_r3: got %h expected 0", D_rs_data); else n_pass++;
    n_total++; if (D_stall !== 1'b0) $display("FAIL mid_reset_stall: got %b expected 0", D_stall); else n_pass++;
    n_total++; if (dbg_wcount !== 32'd0) $display("FAIL mid_reset_wcount: got %0d expected 0", dbg_wcount); else n_pass++;
    n_total++; if (dbg_wnum !== 5'd0) $display("FAIL mid_reset_wnum: got %0d expected 0", dbg_wnum); else n_pass++;
    step();
    resetn = 1'b1;
    step();
    #1;
    n_total++; if (D_stall !== 1'b0) $display("FAIL post_reset_stall: got %b expected 0", D_stall); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_r0_write();
    test_load_use();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- MIPS general-purpose register file. It is the sink end of the write-back interface: it consumes the WB stage's address, write-enable and data outputs.
- Serves two combinational read ports to ID, with same-cycle WB→ID bypass.
- Keeps a per-register load-pending scoreboard so ID can stall on load-use hazards.
- Emits a registered write-back trace for debug and co-simulation.

Parameters:
- DATA_W, `INSTR_WIDTH (32): register data width.
- NREG, 32: number of architectural registers. Fixed; address width is 5.
- PEND_W, 2: width of each scoreboard counter. Up to 3 loads may be in flight.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- W_WB_addr  in  5  write address from WB.
- W_WB_w_reg_ena  in  1  write enable from WB.
- W_WB_wb_data  in  DATA_W  write data from WB.
- W_WB_is_load  in  1  the WB-stage instruction is a load; enables the scoreboard decrement.
- D_rs_addr  in  5  read port A address.
- D_rt_addr  in  5  read port B address.
- D_rs_data  out  DATA_W  read port A data.
- D_rt_data  out  DATA_W  read port B data.
- D_issue_load  in  1  ID issues a load this cycle.
- D_issue_rd  in  5  destination register of the issued load.
- D_stall  out  1  load-use hazard on rs or rt.
- dbg_wen  out  1  registered trace: write occurred.
- dbg_wnum  out  5  registered trace: register written.
- dbg_wdata  out  DATA_W  registered trace: data written.
- dbg_wcount  out  32  count of architectural writes, wraps.

Behaviour:
- Reset: resetn low asynchronously clears the following.
  - All registers r0..r31 to 0.
  - All scoreboard counters to 0.
  - dbg_wen, dbg_wnum, dbg_wdata and dbg_wcount to 0.
- Reset mid-operation discards in-flight pending state. Outputs settle to reset values combinationally: read data 0, D_stall 0.
- Write:
  - On a rising clk with W_WB_w_reg_ena=1 and W_WB_addr≠0, r[W_WB_addr] is updated to W_WB_wb_data.
  - Writes to r0 are dropped.
- Read: combinational.
  - Address 0 always returns 0.
  - If the address equals W_WB_addr, W_WB_w_reg_ena=1 and the address is nonzero, the port returns W_WB_wb_data (bypass, write-first). Otherwise it returns r[addr].
  - The two ports are independent; both may bypass in the same cycle.
- Scoreboard: pend[i] is a PEND_W-bit counter; pend[0] is always 0.
  - Increment: D_issue_load=1 and D_issue_rd≠0 increments pend[D_issue_rd].
  - Decrement: W_WB_w_reg_ena=1, W_WB_is_load=1 and W_WB_addr≠0 decrements pend[W_WB_addr].
  - Increment and decrement on the same register in the same cycle leave the counter unchanged.
  - Increment at max (3) saturates and holds. Decrement at 0 holds at 0. Both are protocol errors and are flagged by a simulation-only assertion.
- Stall:
  - D_stall = (pend_eff[rs] ≠ 0) | (pend_eff[rt] ≠ 0).
  - pend_eff[x] is pend[x] minus 1 when the same-cycle WB load write targets x, otherwise pend[x].
  - A load completing this cycle is covered by the bypass and does not stall.
  - Address 0 never stalls. D_stall is combinational.
- Trace:
  - One cycle after any clock edge with W_WB_w_reg_ena=1 and W_WB_addr≠0:
    - dbg_wen=1.
    - dbg_wnum and dbg_wdata are the captured address and data.
    - dbg_wcount has been incremented by 1, wrapping from 0xFFFFFFFF to 0.
  - Otherwise dbg_wen=0, and dbg_wnum/dbg_wdata hold their last values.
- Latency: write to read visibility is 0 cycles via bypass; trace appears 1 cycle after the write.

Decomposition:
- Shared package/defines:
  - `INSTR_WIDTH.
  - REG_ADDR_W=5.
  - REG_ZERO=5'd0.
  - PEND_MAX=3.
- One sub-module, regfile_scoreboard, holding the pend counters, the saturation logic and the D_stall computation. The storage array, bypass and trace stay in the top module.

Test Plan:
- Reset, then read rs=5 and rt=31 → both 0. dbg_wcount=0, D_stall=0.
- WB write r7=0xDEADBEEF while D_rs_addr=7 in the same cycle → D_rs_data=0xDEADBEEF that cycle. Next cycle dbg_wen=1, dbg_wnum=7, dbg_wdata=0xDEADBEEF, dbg_wcount=1.
- WB write r0=0x12345678 → reading r0 returns 0, and the bypass does not fire. dbg_wen stays 0 and dbg_wcount is unchanged.
- Issue a load to r9, then set D_rt_addr=9 → D_stall=1 for the following cycles. In the cycle WB writes r9 with is_load=1: D_stall=0 and D_rt_data equals the WB data.
- Two loads to r4 issued back-to-back, then one WB load write to r4 → pend[4]=1 and D_stall remains 1 when reading r4. After the second WB load write, D_stall=0.
- Issue a load to r3 and a WB load write to r3 in the same cycle with pend[3]=1 → pend[3] stays 1.
- Assert resetn low mid-sequence with pend[3]=2 and r3 nonzero → r3 reads 0 and D_stall=0 immediately, without waiting for a clock edge.
